// File: rtl/device_info_framer.sv
// device_info_framer
//   Waits for the device-info block's DNA and IDCODE to settle, latches them
//   once, and on request streams a fixed 14-byte identification frame over a
//   valid/ready byte interface.
//
//   Frame (MSB first): HEADER_BYTE, idcode[31:0] (4 bytes),
//                      die_serial[63:0] (8 bytes), check byte.
//   Check byte: XOR of bytes 0-12 by default. When DEVICE_INFO_FRAMER_CRC8_EN
//   is defined it is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   die_serial      : DNA input; bit 56 marks shift complete
//   idcode          : IDCODE input; 0 means not yet read
//   info_valid      : latched values are final
//   serial_latched  : latched die_serial
//   idcode_latched  : latched idcode
//   req             : single-cycle frame request
//   busy            : frame in progress
//   tx_data/tx_valid/tx_ready : byte stream handshake
module device_info_framer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic [7:0]  HEADER_BYTE   = 8'hDE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] die_serial,
  input  logic [31:0] idcode,
  output logic        info_valid,
  output logic [63:0] serial_latched,
  output logic [31:0] idcode_latched,
  input  logic        req,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(12);
  localparam logic [IDX_W-1:0] CHECK_IDX     = IDX_W'(13);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_INFO, IDLE, SEND, CKSUM} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      prev_serial_q, prev_serial_d;
  logic [31:0]      prev_idcode_q, prev_idcode_d;
  logic             pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cksum_q, cksum_d;
  logic             info_valid_d, busy_d, tx_valid_d;
  logic [63:0]      serial_latched_d;
  logic [31:0]      idcode_latched_d;
  logic [7:0]       tx_data_d;

  logic             stable_c;
  logic             accept_c;
  logic [IDX_W-1:0] next_idx_c;
  logic [7:0]       next_byte_c;
  logic [7:0]       cksum_upd_c;

  // Fold one accepted byte into the running check value.
  function automatic logic [7:0] check_update(input logic [7:0] acc, input logic [7:0] b);
`ifdef DEVICE_INFO_FRAMER_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc ^ b;
`endif
  endfunction

  // Inputs must match the previous sample and both look fully read.
  assign stable_c = (die_serial == prev_serial_q) && (idcode == prev_idcode_q) &&
                    die_serial[56] && (idcode != 32'h0);
  assign accept_c = tx_valid && tx_ready;
  assign next_idx_c  = idx_q + IDX_W'(1);
  assign cksum_upd_c = check_update(cksum_q, tx_data);

  // Payload byte for the index about to be presented.
  always_comb begin
    next_byte_c = HEADER_BYTE;
    case (next_idx_c)
      4'd1:    next_byte_c = idcode_latched[31:24];
      4'd2:    next_byte_c = idcode_latched[23:16];
      4'd3:    next_byte_c = idcode_latched[15:8];
      4'd4:    next_byte_c = idcode_latched[7:0];
      4'd5:    next_byte_c = serial_latched[63:56];
      4'd6:    next_byte_c = serial_latched[55:48];
      4'd7:    next_byte_c = serial_latched[47:40];
      4'd8:    next_byte_c = serial_latched[39:32];
      4'd9:    next_byte_c = serial_latched[31:24];
      4'd10:   next_byte_c = serial_latched[23:16];
      4'd11:   next_byte_c = serial_latched[15:8];
      4'd12:   next_byte_c = serial_latched[7:0];
      default: next_byte_c = HEADER_BYTE;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    prev_serial_d    = die_serial;
    prev_idcode_d    = idcode;
    pending_d        = pending_q;
    idx_d            = idx_q;
    cksum_d          = cksum_q;
    info_valid_d     = info_valid;
    serial_latched_d = serial_latched;
    idcode_latched_d = idcode_latched;
    busy_d           = busy;
    tx_valid_d       = tx_valid;
    tx_data_d        = tx_data;

    case (state_q)
      WAIT_INFO: begin
        if (req) pending_d = 1'b1;
        if (stable_c) begin
          if (cnt_q == CNT_LAST) begin
            serial_latched_d = die_serial;
            idcode_latched_d = idcode;
            info_valid_d     = 1'b1;
            cnt_d            = '0;
            state_d          = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      IDLE: begin
        if (req || pending_q) begin
          pending_d  = 1'b0;
          idx_d      = '0;
          cksum_d    = '0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER_BYTE;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (accept_c) begin
          cksum_d = cksum_upd_c;
          if (idx_q == LAST_DATA_IDX) begin
            idx_d     = CHECK_IDX;
            tx_data_d = cksum_upd_c;
            state_d   = CKSUM;
          end else begin
            idx_d     = next_idx_c;
            tx_data_d = next_byte_c;
          end
        end
      end
      CKSUM: begin
        if (accept_c) begin
          idx_d      = '0;
          busy_d     = 1'b0;
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = WAIT_INFO;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_INFO;
      cnt_q          <= '0;
      prev_serial_q  <= '0;
      prev_idcode_q  <= '0;
      pending_q      <= 1'b0;
      idx_q          <= '0;
      cksum_q        <= '0;
      info_valid     <= 1'b0;
      serial_latched <= '0;
      idcode_latched <= '0;
      busy           <= 1'b0;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prev_serial_q  <= prev_serial_d;
      prev_idcode_q  <= prev_idcode_d;
      pending_q      <= pending_d;
      idx_q          <= idx_d;
      cksum_q        <= cksum_d;
      info_valid     <= info_valid_d;
      serial_latched <= serial_latched_d;
      idcode_latched <= idcode_latched_d;
      busy           <= busy_d;
      tx_valid       <= tx_valid_d;
      tx_data        <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_device_info_framer.sv
// Testbench for device_info_framer: settle detection, transient filtering,
// frame content under several ready patterns, early requests, and reset
// during a frame. Inputs are driven and outputs sampled on the falling edge.
module tb_device_info_framer;

  localparam int unsigned STABLE = 16;
  localparam logic [7:0]  HDR    = 8'hDE;

  typedef logic [13:0][7:0] frame_t;
  typedef struct {
    logic [63:0] serial;
    logic [31:0] id;
    int          mode;   // 0: ready high, 1: 3-cycle stall on byte 5, 2: random ready
    bit          noise;  // random req pulses while busy
    frame_t      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] die_serial;
  logic [31:0] idcode;
  logic        info_valid;
  logic [63:0] serial_latched;
  logic [31:0] idcode_latched;
  logic        req;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int tests = 0;
  int fails = 0;

  device_info_framer #(.STABLE_CYCLES(STABLE), .HEADER_BYTE(HDR)) dut (
    .clk(clk), .rst(rst), .die_serial(die_serial), .idcode(idcode),
    .info_valid(info_valid), .serial_latched(serial_latched),
    .idcode_latched(idcode_latched), .req(req), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference frame: header, IDCODE, DNA as one big-endian message, then the check byte.
  function automatic frame_t model_frame(input logic [63:0] s, input logic [31:0] id);
    logic [103:0] body;
    logic [7:0]   c;
    logic         fb;
    frame_t       f;
    body = {HDR, id, s};
    c = 8'h00;
    for (int i = 0; i < 13; i++) f[i] = body[8*(12-i) +: 8];
`ifdef DEVICE_INFO_FRAMER_CRC8_EN
    for (int b = 103; b >= 0; b--) begin
      fb = c[7] ^ body[b];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
`else
    fb = 1'b0;
    for (int i = 0; i < 13; i++) c = c ^ f[i];
`endif
    f[13] = c;
    return f;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Drive values and measure how many falling edges pass until info_valid.
  task automatic settle(input logic [63:0] s, input logic [31:0] id, input bit early_req);
    int k;
    die_serial = s;
    idcode     = id;
    k = 0;
    while (!info_valid && k < 200) begin
      req = early_req && (k == 2 || k == 5);
      step();
      k++;
    end
    req = 1'b0;
    // Sampling edge plus STABLE further matching edges.
    chk("settle_latency", 64'(k), 64'(STABLE + 1));
    chk("serial_latched", serial_latched, s);
    chk("idcode_latched", 64'(idcode_latched), 64'(id));
  endtask

  // Collect one frame; abort_at >= 0 asserts rst while that byte is on the bus.
  task automatic run_frame(input frame_t exp, input int mode, input bit issue_req,
                           input bit noise, input int abort_at);
    int   got, iters, stalls, busy_after;
    bit   prev_stalled;
    logic [7:0] prev_data;
    bit   rdy;
    if (issue_req) begin
      req = 1'b1;
      step();
      req = 1'b0;
    end
    chk("start_busy", 64'(busy), 64'(1));
    got = 0; iters = 0; stalls = 0; prev_stalled = 0; prev_data = '0;
    while (got < 14 && iters < 200) begin
      if (prev_stalled) begin
        chk("hold_valid", 64'(tx_valid), 64'(1));
        chk("hold_data", 64'(tx_data), 64'(prev_data));
      end
      chk("no_bubble", 64'(tx_valid), 64'(1));
      if (abort_at >= 0 && got == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_tx_valid", 64'(tx_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_info_valid", 64'(info_valid), 64'(0));
        return;
      end
      case (mode)
        1:       rdy = !(got == 5 && stalls < 3);
        2:       rdy = 1'($urandom % 2);
        default: rdy = 1'b1;
      endcase
      if (!rdy && got == 5) begin
        stalls++;
        if (mode == 1) chk("stall_byte5", 64'(tx_data), 64'(exp[5]));
      end
      tx_ready = rdy;
      // A request on the last-byte acceptance edge must be ignored.
      req = (got == 13 && rdy) ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);
      if (tx_valid && rdy) begin
        chk($sformatf("byte%0d", got), 64'(tx_data), 64'(exp[got]));
        got++;
      end
      prev_stalled = tx_valid && !rdy;
      prev_data    = tx_data;
      step();
      iters++;
    end
    req = 1'b0;
    tx_ready = 1'b0;
    chk("frame_complete", 64'(got), 64'(14));
    if (mode == 0) chk("frame_cycles", 64'(iters), 64'(14));
    chk("end_busy", 64'(busy), 64'(0));
    chk("end_tx_valid", 64'(tx_valid), 64'(0));
    busy_after = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy || tx_valid) busy_after++;
    end
    chk("no_extra_frame", 64'(busy_after), 64'(0));
  endtask

  initial begin
    vec_t  tbl[$];
    vec_t  v;
    frame_t spec_lit;
    logic [111:0] spec_bytes;
    logic [63:0] a;
    int bad;

    a = 64'h0100000000000001;
    spec_bytes = 112'hDE_13_63_10_93_01_00_00_00_00_00_00_01_2D;
    for (int i = 0; i < 14; i++) spec_lit[i] = spec_bytes[8*(13-i) +: 8];
`ifdef DEVICE_INFO_FRAMER_CRC8_EN
    spec_lit = model_frame(a, 32'h13631093);
`endif

    // Vector table: inputs, ready pattern and expected frame.
    tbl.push_back('{serial: a, id: 32'h13631093, mode: 1, noise: 0, exp: spec_lit});
    tbl.push_back('{serial: 64'h01FF00001234ABCD, id: 32'h0362D093, mode: 2, noise: 1,
                    exp: model_frame(64'h01FF00001234ABCD, 32'h0362D093)});
    tbl.push_back('{serial: 64'h0100000000000000, id: 32'h00000001, mode: 0, noise: 0,
                    exp: model_frame(64'h0100000000000000, 32'h00000001)});
    for (int r = 0; r < 3; r++) begin
      v.serial = {32'($urandom), 32'($urandom)} | 64'h0100000000000000;
      v.id     = 32'($urandom) | 32'h1;
      v.mode   = r % 3;
      v.noise  = 1'b1;
      v.exp    = model_frame(v.serial, v.id);
      tbl.push_back(v);
    end

    rst = 1'b1; die_serial = '0; idcode = '0; req = 1'b0; tx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_info_valid", 64'(info_valid), 64'(0));
    chk("rst_serial", serial_latched, 64'(0));
    chk("rst_idcode", 64'(idcode_latched), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));

    // Shift-complete bit low, then IDCODE zero: never valid.
    die_serial = a & ~64'h0100000000000000; idcode = 32'h13631093;
    bad = 0;
    for (int i = 0; i < 30; i++) begin step(); if (info_valid) bad++; end
    chk("no_valid_bit56_low", 64'(bad), 64'(0));
    die_serial = a; idcode = 32'h0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin step(); if (info_valid) bad++; end
    chk("no_valid_idcode_zero", 64'(bad), 64'(0));

    // Transient filter: toggle every 10 cycles with bit 56 set.
    idcode = 32'h13631093;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      die_serial = (t % 2 == 0) ? a : (a ^ 64'h10);
      for (int i = 0; i < 10; i++) begin step(); if (info_valid) bad++; end
    end
    chk("transient_filtered", 64'(bad), 64'(0));
    settle(a, 32'h13631093, 1'b0);
    run_frame(spec_lit, 0, 1'b1, 1'b0, -1);

    // Table-driven frames, each after a fresh reset and settle.
    foreach (tbl[i]) begin
      do_reset();
      settle(tbl[i].serial, tbl[i].id, 1'b0);
      run_frame(tbl[i].exp, tbl[i].mode, 1'b1, tbl[i].noise, -1);
    end

    // Early requests coalesce into one frame right after info_valid.
    do_reset();
    settle(a, 32'h13631093, 1'b1);
    chk("early_busy_at_valid", 64'(busy), 64'(0));
    step();
    chk("early_tx_valid", 64'(tx_valid), 64'(1));
    chk("early_header", 64'(tx_data), 64'(HDR));
    run_frame(spec_lit, 0, 1'b0, 1'b0, -1);

    // Reset during byte 7, then re-settle and send a full frame.
    run_frame(spec_lit, 0, 1'b1, 1'b0, 7);
    settle(a, 32'h13631093, 1'b0);
    run_frame(spec_lit, 0, 1'b1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/device_info_framer.md
Name: device_info_framer

Overview:
- Sits directly downstream of the 7-series device-info block and consumes its die_serial (DNA) and idcode outputs.
- Waits until both values have settled, then latches them and presents them with a valid flag.
- On request, streams them as a fixed 14-byte frame over a valid/ready byte interface. This feeds the UART/debug transport so the host can identify the board.

Parameters:
- STABLE_CYCLES, 16, consecutive cycles the inputs must stay unchanged before they are accepted (legal range 1 to 65535).
- HEADER_BYTE, 8'hDE, first byte of every frame.

Ports:
- clk  input  1  system clock; same clock as the device-info block.
- rst  input  1  synchronous active-high reset.
- die_serial  input  64  DNA from the upstream block; bit 56 set marks shift complete.
- idcode  input  32  JTAG IDCODE from the upstream block; 0 means not yet read.
- info_valid  output  1  latched values are final.
- serial_latched  output  64  latched die_serial.
- idcode_latched  output  32  latched idcode.
- req  input  1  single-cycle request to send one frame.
- busy  output  1  a frame is in progress.
- tx_data  output  8  frame byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts the byte when tx_valid and tx_ready are both high.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: info_valid=0, serial_latched=0, idcode_latched=0, busy=0, tx_valid=0, tx_data=0. State=WAIT_INFO, stable counter=0, pending=0, byte index=0, checksum=0.
- Stability detect (WAIT_INFO):
  - Register the previous cycle's {die_serial, idcode}.
  - The counter increments while the inputs equal the previous sample, die_serial[56]=1 and idcode!=0. Any other cycle clears it to 0.
  - When the counter reaches STABLE_CYCLES-1 with the condition still true: latch both inputs, set info_valid=1 on the next edge, and go to IDLE.
  - Bit 56 can go high transiently during shifting; the stability counter is what filters this.
- After info_valid rises, the latched values and info_valid hold until rst. Later input changes are ignored.
- req handling:
  - req during WAIT_INFO sets pending=1. Requests coalesce; at most one frame is owed.
  - In IDLE, req or pending starts a frame and clears pending.
  - req while busy=1 is ignored and not queued.
- Frame, MSB first, 14 bytes:
  - HEADER_BYTE
  - idcode_latched[31:24], [23:16], [15:8], [7:0]
  - serial_latched[63:56] through [7:0]
  - checksum
- States:
  - WAIT_INFO → IDLE once values are latched.
  - IDLE → SEND when a frame starts. The cycle after req is sampled, busy=1, tx_valid=1 and tx_data=HEADER_BYTE.
  - SEND → CKSUM after byte 12 is accepted.
  - CKSUM → IDLE after the checksum byte is accepted. busy=0 and tx_valid=0 on the next cycle.
- Handshake:
  - tx_data and tx_valid hold stable while tx_valid=1 and tx_ready=0.
  - On acceptance, the next byte is presented on the following cycle with no bubble, so sustained tx_ready gives 1 byte/clk and 14 cycles per frame.
  - tx_ready while tx_valid=0 has no effect.
- Checksum: XOR of bytes 0–12, accumulated as each byte is accepted and cleared when a frame starts.
- Back-to-back: a req sampled in the same cycle the last byte is accepted is ignored (busy is still 1).
- rst mid-frame: tx_valid=0 and busy=0 from the next cycle. The frame is truncated with no checksum, everything returns to reset values, and the block re-runs stability detection.

Optional Feature:
- Macro: DEVICE_INFO_FRAMER_CRC8_EN.
- Defined: byte 13 is CRC-8 over bytes 0–12, poly 0x07, init 0x00, no reflection, no final XOR. It is computed bytewise as each byte is accepted.
- Undefined: byte 13 is the XOR checksum.
- Frame length and timing are identical in both builds.

Test Plan:
- Settle detect: hold die_serial=64'h0100000000000001, idcode=32'h13631093 with STABLE_CYCLES=16 → info_valid rises exactly 16 cycles after the first stable sample. Latched values match the inputs.
- Transient filter: toggle die_serial every 10 cycles with bit 56=1 → info_valid stays 0. Then hold the inputs → valid after STABLE_CYCLES.
- Frame content: send those values with tx_ready=1 → bytes DE 13 63 10 93 01 00 00 00 00 00 00 01 2D on 14 consecutive cycles, then busy=0.
- Backpressure: drive tx_ready low for 3 cycles on byte 5 → tx_data=8'h01 held with tx_valid=1, no byte lost or duplicated.
- Early request: pulse req twice during WAIT_INFO → exactly one frame starts the cycle after info_valid rises.
- Reset mid-frame: assert rst during byte 7 → tx_valid=0 and busy=0 next cycle, info_valid=0. A fresh frame after re-settle starts with DE.
